uart_rx_param: RTL and testbench

- Parametrised successor UART receiver.
- Generalises the fixed 8N1, 115200-baud receiver to configurable data bits, stop bits and oversampling.
- Keeps 3-point mid-bit majority voting. Adds a valid/ready output holding register with overrun detection, plus optional parity checking.
- Sits between the serial pin and the system-side consumer, paired with the existing UART transmitter.

---
 rtl/uart_rx_param.sv | 266 ++++++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param -- parametrised UART receiver with 3-point majority voting.
//
// Receives frames of 1 start bit, DATA_BITS data bits (LSB first), an
// optional parity bit and STOP_BITS stop bits.
//
// The line is oversampled DIVISION times per bit. Each bit value is the
// 2-of-3 majority of the samples taken on ticks DIVISION/2-1, DIVISION/2 and
// DIVISION/2+1 of that bit.
//
// Completed words go into a valid/ready holding register. A frame that
// completes while an unaccepted word is still held is dropped, and
// o_rx_overrun pulses for one cycle.
//
// Build option:
//   UART_RX_PARITY_EN - when defined, each frame carries one parity bit after
//                       the data bits. PARITY_ODD selects even (0) or odd (1)
//                       parity. When undefined, o_parity_error is tied to 0.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   i_rx_d         serial line, idle high, asynchronous to clk
//   i_rx_ready     consumer accepts the held word
//   o_rx_d         received word, LSB = first data bit
//   o_rx_valid     held word valid
//   o_rx_error     framing error flag for the held word
//   o_parity_error parity error flag for the held word
//   o_rx_overrun   one-cycle pulse: a completed frame was dropped
//   o_rx_busy      high while a frame is being received
module uart_rx_param #(
  parameter int SYS_CLK    = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DIVISION   = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_rx_d,
  input  logic                 i_rx_ready,
  output logic [DATA_BITS-1:0] o_rx_d,
  output logic                 o_rx_valid,
  output logic                 o_rx_error,
  output logic                 o_parity_error,
  output logic                 o_rx_overrun,
  output logic                 o_rx_busy
);

  localparam int TICK_CLKS = SYS_CLK / (BAUD_RATE * DIVISION);
  localparam int PW = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;
  localparam int TW = $clog2(DIVISION);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CLKS - 1);
  localparam logic [TW-1:0] SAMP0      = TW'(DIVISION / 2 - 1);
  localparam logic [TW-1:0] SAMP1      = TW'(DIVISION / 2);
  localparam logic [TW-1:0] SAMP2      = TW'(DIVISION / 2 + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(DIVISION - 1);
  localparam logic [3:0]    DBIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic          STOP_LAST  = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [1:0]           samp_q, samp_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 frm_err_q, frm_err_d;
  logic                 commit_q, commit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_err_q, par_err_d;
  logic                 perr_q, perr_d;
`endif

  logic rx_s, tick, vote, vote_tick, bit_end;

  always_comb begin
    rx_s      = sync2_q;
    tick      = (state_q != IDLE) && (presc_q == PRESC_LAST);
    vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    vote_tick = tick && (tick_cnt_q == SAMP2);
    bit_end   = tick && (tick_cnt_q == TICK_LAST);

    state_d    = state_q;
    sync1_d    = i_rx_d;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    presc_d    = presc_q;
    tick_cnt_d = tick_cnt_q;
    samp_d     = samp_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    frm_err_d  = frm_err_q;
    commit_d   = 1'b0;
    data_d     = data_q;
    valid_d    = valid_q;
    err_d      = err_q;
    overrun_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d  = par_err_q;
    perr_d     = perr_q;
`endif

    // Prescaler and tick counter run only while a frame is in progress.
    if (state_q != IDLE) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
    end
    if (tick) begin
      tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
      if (tick_cnt_q == SAMP0) samp_d[0] = rx_s;
      if (tick_cnt_q == SAMP1) samp_d[1] = rx_s;
    end

    case (state_q)
      IDLE: begin
        // A falling edge on the synchronised line starts a frame. The
        // prescaler phase is realigned to this edge.
        if (prev_q && !rx_s) begin
          state_d    = START;
          presc_d    = '0;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          frm_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
          par_err_d  = 1'b0;
`endif
        end
      end
      START: begin
        if (vote_tick && vote) begin
          state_d = IDLE;  // glitch, not a real start bit
        end else if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (vote_tick) shift_d = {vote, shift_q[DATA_BITS-1:1]};
        if (bit_end) begin
          if (bit_cnt_q == DBIT_LAST) begin
            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (vote_tick) par_err_d = vote ^ (^shift_q) ^ (PARITY_ODD != 0);
        if (bit_end) state_d = STOP;
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        if (vote_tick) begin
          if (!vote) frm_err_d = 1'b1;
          // Leave right after the last vote so that a following start edge
          // is not missed.
          if (stop_cnt_q == STOP_LAST) begin
            state_d  = IDLE;
            commit_d = 1'b1;
          end
        end
        if (bit_end) stop_cnt_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Output holding register. A commit takes priority over a plain
    // handshake; a commit on a full, unaccepted register is dropped.
    if (commit_q) begin
      if (!valid_q || i_rx_ready) begin
        data_d  = shift_q;
        err_d   = frm_err_q;
        valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
        perr_d  = par_err_q;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && i_rx_ready) begin
      valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      presc_q    <= '0;
      tick_cnt_q <= '0;
      samp_q     <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      frm_err_q  <= 1'b0;
      commit_q   <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q  <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      presc_q    <= presc_d;
      tick_cnt_q <= tick_cnt_d;
      samp_q     <= samp_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      frm_err_q  <= frm_err_d;
      commit_q   <= commit_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      overrun_q  <= overrun_d;
      busy_q     <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_err_q  <= par_err_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign o_rx_d       = data_q;
  assign o_rx_valid   = valid_q;
  assign o_rx_error   = err_q;
  assign o_rx_overrun = overrun_q;
  assign o_rx_busy    = busy_q;

`ifdef UART_RX_PARITY_EN
  assign o_parity_error = perr_q;
`else
  logic unused_cfg;
  assign unused_cfg     = (PARITY_ODD != 0);
  assign o_parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param -- directed bench for uart_rx_param at default parameters
// (50 MHz clock, 115200 baud, x16 oversampling -> 432 clocks per bit).
module tb_uart_rx_param;

  localparam int BIT_CLKS = 432;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_rx_d = 1'b1;
  logic       i_rx_ready = 1'b0;
  logic [7:0] o_rx_d;
  logic       o_rx_valid, o_rx_error, o_parity_error, o_rx_overrun, o_rx_busy;

  int total_cnt = 0;
  int bad_cnt   = 0;
  int ovr_cnt   = 0;

  uart_rx_param dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_rx_d         (i_rx_d),
    .i_rx_ready     (i_rx_ready),
    .o_rx_d         (o_rx_d),
    .o_rx_valid     (o_rx_valid),
    .o_rx_error     (o_rx_error),
    .o_parity_error (o_parity_error),
    .o_rx_overrun   (o_rx_overrun),
    .o_rx_busy      (o_rx_busy)
  );

  always #10 clk = ~clk;

  // Count every cycle in which the overrun pulse is high.
  always @(negedge clk) if (o_rx_overrun) ovr_cnt <= ovr_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // One bit period. With glitch set, the line is inverted around the middle
  // sample so that exactly one of the three votes is wrong.
  task automatic send_bit(input logic v, input logic glitch);
    for (int c = 0; c < BIT_CLKS; c++) begin
      i_rx_d = (glitch && c >= 235 && c < 255) ? ~v : v;
      @(negedge clk);
    end
    i_rx_d = v;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_v,
                            input logic glitch, input logic bad_par);
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(data[i], glitch);
`ifdef UART_RX_PARITY_EN
    send_bit((^data) ^ bad_par, glitch);
`else
    if (bad_par) begin end
`endif
    send_bit(stop_v, glitch);
    i_rx_d = 1'b1;
    @(negedge clk);
  endtask

  task automatic accept_word();
    i_rx_ready = 1'b1;
    @(negedge clk);
    i_rx_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_valid", {31'd0, o_rx_valid}, 32'd0);
    check_eq("rst_busy", {31'd0, o_rx_busy}, 32'd0);
    check_eq("rst_data", {24'd0, o_rx_d}, 32'd0);
    check_eq("rst_err", {31'd0, o_rx_error}, 32'd0);
    check_eq("rst_ovr", {31'd0, o_rx_overrun}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Clean 0x55, then handshake clears valid on the next cycle.
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    check_eq("f55_valid", {31'd0, o_rx_valid}, 32'd1);
    check_eq("f55_data", {24'd0, o_rx_d}, 32'h55);
    check_eq("f55_err", {31'd0, o_rx_error}, 32'd0);
    check_eq("f55_perr", {31'd0, o_parity_error}, 32'd0);
    accept_word();
    check_eq("f55_cleared", {31'd0, o_rx_valid}, 32'd0);

    // Ready while nothing is held has no effect.
    accept_word();
    check_eq("ready_novalid", {31'd0, o_rx_valid}, 32'd0);

    // False start: 100 clocks low.
    i_rx_d = 1'b0;
    repeat (50) @(negedge clk);
    check_eq("fs_busy_mid", {31'd0, o_rx_busy}, 32'd1);
    repeat (50) @(negedge clk);
    i_rx_d = 1'b1;
    repeat (600) @(negedge clk);
    check_eq("fs_valid", {31'd0, o_rx_valid}, 32'd0);
    check_eq("fs_busy_end", {31'd0, o_rx_busy}, 32'd0);

    // Stop bit driven low -> framing error, word still presented.
    send_frame(8'hA3, 1'b0, 1'b0, 1'b0);
    check_eq("fA3_valid", {31'd0, o_rx_valid}, 32'd1);
    check_eq("fA3_data", {24'd0, o_rx_d}, 32'hA3);
    check_eq("fA3_err", {31'd0, o_rx_error}, 32'd1);
    accept_word();
    repeat (20) @(negedge clk);

    // One of the three samples wrong on every bit -> voted out.
    send_frame(8'h0F, 1'b1, 1'b1, 1'b0);
    check_eq("f0F_valid", {31'd0, o_rx_valid}, 32'd1);
    check_eq("f0F_data", {24'd0, o_rx_d}, 32'h0F);
    check_eq("f0F_err", {31'd0, o_rx_error}, 32'd0);
    accept_word();

    // Back-to-back with no acceptance -> second frame dropped.
    ovr_cnt = 0;
    send_frame(8'h12, 1'b1, 1'b0, 1'b0);
    send_frame(8'h34, 1'b1, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    check_eq("ovr_data", {24'd0, o_rx_d}, 32'h12);
    check_eq("ovr_valid", {31'd0, o_rx_valid}, 32'd1);
    check_eq("ovr_pulses", ovr_cnt, 32'd1);

    // Reset in the middle of data bit 3 while a word is still held.
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    i_rx_d = 1'b0;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rstm_valid", {31'd0, o_rx_valid}, 32'd0);
    check_eq("rstm_data", {24'd0, o_rx_d}, 32'd0);
    check_eq("rstm_busy", {31'd0, o_rx_busy}, 32'd0);
    check_eq("rstm_err", {31'd0, o_rx_error}, 32'd0);
    repeat (5) @(negedge clk);
    i_rx_d = 1'b1;
    rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    check_eq("rstm_discard", {31'd0, o_rx_valid}, 32'd0);

    // 0xC3 with a corrupted parity bit (only present with parity enabled).
    send_frame(8'hC3, 1'b1, 1'b0, 1'b1);
    check_eq("fC3_valid", {31'd0, o_rx_valid}, 32'd1);
    check_eq("fC3_data", {24'd0, o_rx_d}, 32'hC3);
    check_eq("fC3_err", {31'd0, o_rx_error}, 32'd0);
`ifdef UART_RX_PARITY_EN
    check_eq("fC3_perr", {31'd0, o_parity_error}, 32'd1);
`else
    check_eq("fC3_perr", {31'd0, o_parity_error}, 32'd0);
`endif
    accept_word();
    check_eq("fC3_cleared", {31'd0, o_rx_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
